// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipelined TSC control unit.
// Holds opcode/func codes, the staged control words, the forwarding select and FSM state enums.
package pipe_ctrl_pkg;

    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_ALU = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    localparam logic [3:0] ALU_ORI  = 4'd3;
    localparam logic [3:0] ALU_LHI  = 4'd8;
    localparam logic [3:0] ALU_PASS = 4'd9;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       jr;
        logic       reg_write;
        logic       mem_to_reg;
        logic       pc_to_reg;
        logic       wwd;
        logic       hlt;
    } ctrl_t;

    // Only the write-back side of the control word travels past EX.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic pc_to_reg;
        logic wwd;
        logic hlt;
    } wb_ctrl_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hlt_state_e;

    function automatic wb_ctrl_t to_wb(input ctrl_t c);
        wb_ctrl_t w;
        w.reg_write  = c.reg_write;
        w.mem_to_reg = c.mem_to_reg;
        w.pc_to_reg  = c.pc_to_reg;
        w.wwd        = c.wwd;
        w.hlt        = c.hlt;
        return w;
    endfunction

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational ID-stage decoder: opcode/func into a control word, destination register
// and the source-operand usage flags that feed hazard detection.
module pipe_ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 2
) (
    input  logic [3:0]        opcode,
    input  logic [5:0]        func,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    output ctrl_t             ctrl,
    output logic [REG_AW-1:0] dst,
    output logic              use_rs,
    output logic              use_rt
);

    logic r_alu;
    logic is_imm_wr;
    logic is_jal;
    logic is_jrl;
    logic is_jpr;
    logic is_wwd;
    logic is_hlt;

    always_comb begin
        r_alu     = (opcode == OP_ALU) && (func[5:3] == 3'b000);
        is_imm_wr = (opcode >= OP_ADI) && (opcode <= OP_LWD);
        is_jal    = (opcode == OP_JAL);
        is_jrl    = (opcode == OP_ALU) && (func == FN_JRL);
        is_jpr    = (opcode == OP_ALU) && (func == FN_JPR);
        is_wwd    = (opcode == OP_ALU) && (func == FN_WWD);
        is_hlt    = (opcode == OP_ALU) && (func == FN_HLT);

        ctrl            = '0;
        ctrl.alu_src    = (opcode >= OP_ADI) && (opcode <= OP_SWD);
        ctrl.mem_read   = (opcode == OP_LWD);
        ctrl.mem_write  = (opcode == OP_SWD);
        ctrl.jr         = is_jpr || is_jrl;
        ctrl.reg_write  = r_alu || is_imm_wr || is_jal || is_jrl;
        ctrl.mem_to_reg = (opcode == OP_LWD);
        ctrl.pc_to_reg  = is_jal || is_jrl;
        ctrl.wwd        = is_wwd;
        ctrl.hlt        = is_hlt;

        if (r_alu)
            ctrl.alu_op = {1'b0, func[2:0]};
        else if (opcode == OP_ORI)
            ctrl.alu_op = ALU_ORI;
        else if (opcode == OP_LHI)
            ctrl.alu_op = ALU_LHI;
        else if (is_wwd || is_jpr || is_jrl)
            ctrl.alu_op = ALU_PASS;

        dst = '0;
        if (r_alu)
            dst = rd;
        else if (is_imm_wr)
            dst = rt;
        else if (is_jal || is_jrl)
            dst = REG_AW'(2);

        use_rs = !((opcode == OP_LHI) || (opcode == OP_JMP) || is_jal || is_hlt);
        use_rt = (r_alu && (func[3:2] == 2'b00)) || (opcode == OP_SWD)
               || (opcode == OP_BNE) || (opcode == OP_BEQ);
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: stages control words through EX/MEM/WB, detects RAW hazards,
// sequences HLT drain and counts retirements. Define PIPE_CTRL_UNIT_FWD_EN for forwarding.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [3:0]        id_opcode,
    input  logic [5:0]        id_func,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              flush_id,
    output logic [3:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_jr,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic              wb_pc_to_reg,
    output logic              wb_wwd,
    output logic [REG_AW-1:0] wb_dst,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [CNT_W-1:0]  num_inst
);

    ctrl_t             id_ctrl;
    logic [REG_AW-1:0] id_dst;
    logic              id_use_rs;
    logic              id_use_rt;

    ctrl_t             ex_ctrl;
    wb_ctrl_t          mem_ctrl;
    wb_ctrl_t          wb_ctrl;
    logic              ex_valid, mem_valid, wb_valid;
    logic [REG_AW-1:0] ex_dst, mem_dst, wb_dst_q;

    logic              hazard;
    logic              issue;
    logic              fsm_hold;
    hlt_state_e        state, state_nxt;

    pipe_ctrl_decode #(.REG_AW(REG_AW)) u_decode (
        .opcode (id_opcode),
        .func   (id_func),
        .rt     (id_rt),
        .rd     (id_rd),
        .ctrl   (id_ctrl),
        .dst    (id_dst),
        .use_rs (id_use_rs),
        .use_rt (id_use_rt)
    );

    // WB is excluded from hazard checks because the regfile writes before it reads.
`ifdef PIPE_CTRL_UNIT_FWD_EN
    logic ex_hit;

    always_comb begin
        ex_hit = ex_valid && ex_ctrl.reg_write
              && ((id_use_rs && (ex_dst == id_rs)) || (id_use_rt && (ex_dst == id_rt)));
        hazard = id_valid && ex_hit && ex_ctrl.mem_read;
    end
`else
    logic ex_hit, mem_hit;

    always_comb begin
        ex_hit  = ex_valid && ex_ctrl.reg_write
               && ((id_use_rs && (ex_dst == id_rs)) || (id_use_rt && (ex_dst == id_rt)));
        mem_hit = mem_valid && mem_ctrl.reg_write
               && ((id_use_rs && (mem_dst == id_rs)) || (id_use_rt && (mem_dst == id_rt)));
        hazard  = id_valid && (ex_hit || mem_hit);
    end
`endif

    assign issue = id_valid && !ex_redirect && !hazard && (state == ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:    if (issue && id_ctrl.hlt) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (wb_valid && wb_ctrl.hlt) state_nxt = ST_HALTED;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        fsm_hold = (state != ST_RUN);
        halted   = (state == ST_HALTED);
    end

    // Draining/halted holds the front end regardless of a redirect; otherwise redirect beats a hazard.
    assign stall    = fsm_hold || (hazard && !ex_redirect);
    assign flush_id = ex_redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_dst    <= '0;
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
            mem_dst   <= '0;
            wb_valid  <= 1'b0;
            wb_ctrl   <= '0;
            wb_dst_q  <= '0;
            num_inst  <= '0;
        end else begin
            ex_valid  <= issue;
            ex_ctrl   <= issue ? id_ctrl : '0;
            ex_dst    <= issue ? id_dst : '0;
            mem_valid <= ex_valid;
            mem_ctrl  <= to_wb(ex_ctrl);
            mem_dst   <= ex_dst;
            wb_valid  <= mem_valid;
            wb_ctrl   <= mem_ctrl;
            wb_dst_q  <= mem_dst;
            if (wb_valid)
                num_inst <= num_inst + CNT_W'(1);
        end
    end

    assign ex_alu_op     = ex_ctrl.alu_op;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_jr         = ex_ctrl.jr;
    assign wb_reg_write  = wb_valid && wb_ctrl.reg_write;
    assign wb_mem_to_reg = wb_valid && wb_ctrl.mem_to_reg;
    assign wb_pc_to_reg  = wb_valid && wb_ctrl.pc_to_reg;
    assign wb_wwd        = wb_valid && wb_ctrl.wwd;
    assign wb_dst        = wb_valid ? wb_dst_q : '0;

`ifdef PIPE_CTRL_UNIT_FWD_EN
    logic [REG_AW-1:0] ex_rs, ex_rt;
    logic              ex_use_rs, ex_use_rt;
    fwd_sel_e          sel_a, sel_b;
    logic              mem_fwd_ok, wb_fwd_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_use_rs <= 1'b0;
            ex_use_rt <= 1'b0;
        end else begin
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_use_rs <= issue && id_use_rs;
            ex_use_rt <= issue && id_use_rt;
        end
    end

    // A load in MEM has no result yet; the load-use stall keeps that case from ever needing it.
    always_comb begin
        mem_fwd_ok = mem_valid && mem_ctrl.reg_write && !mem_ctrl.mem_to_reg;
        wb_fwd_ok  = wb_valid && wb_ctrl.reg_write;
        sel_a = FWD_REG;
        sel_b = FWD_REG;
        if (ex_use_rs) begin
            if (mem_fwd_ok && (mem_dst == ex_rs))
                sel_a = FWD_MEM;
            else if (wb_fwd_ok && (wb_dst_q == ex_rs))
                sel_a = FWD_WB;
        end
        if (ex_use_rt) begin
            if (mem_fwd_ok && (mem_dst == ex_rt))
                sel_b = FWD_MEM;
            else if (wb_fwd_ok && (wb_dst_q == ex_rt))
                sel_b = FWD_WB;
        end
    end

    assign fwd_a = sel_a;
    assign fwd_b = sel_b;
`else
    assign fwd_a = 2'd0;
    assign fwd_b = 2'd0;
`endif

endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Parametrised pipelined control unit for the 4-stage-post-fetch TSC core (ID/EX/MEM/WB).
- Decodes the ID-stage instruction, registers control words down EX/MEM/WB, and detects RAW hazards to drive stall, flush and optional forwarding selects.
- Sequences HLT drain and counts retired instructions.
- Replaces the purely combinational decoder; the datapath consumes its staged outputs directly.

## Interface
Parameters:
- REG_AW, 2, register-address width (2^REG_AW architectural registers)
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  4  ID opcode
- id_func  in  6  ID function code (opcode 15)
- id_rs, id_rt, id_rd  in  REG_AW each  ID register fields
- ex_redirect  in  1  EX resolved a taken branch/jump; younger instructions are wrong-path
- stall  out  1  hold PC and IF/ID this cycle
- flush_id  out  1  clear IF/ID at next edge
- ex_alu_op  out  4  EX ALU operation
- ex_alu_src, ex_mem_read, ex_mem_write, ex_jr  out  1 each  EX controls
- wb_reg_write, wb_mem_to_reg, wb_pc_to_reg, wb_wwd  out  1 each  WB controls, gated by WB valid
- wb_dst  out  REG_AW  WB destination register
- fwd_a, fwd_b  out  2  EX operand select: 0 regfile, 1 MEM result, 2 WB result (tied 0 without forwarding)
- halted  out  1  HLT retired
- num_inst  out  CNT_W  retired-instruction count

## Operation
- Decode:
  - R-ALU = opcode 15 and func[5:3]==0.
  - Writers: R-ALU, opcodes 4–7, 10, JRL (15/26).
  - Destination: rd for R-ALU; rt for 4–7; register 2 for JAL/JRL.
  - alu_op: func[2:0] for R-ALU; 3 for op 5; 8 for op 6; 9 for WWD (15/28) and JPR/JRL (15/25,26); else 0.
- Operand use:
  - rs used by all except op 6, 9, 10 and HLT (15/29).
  - rt used by R-ALU with func[3:2]==0, SWD (8), BNE/BEQ (0/1).
- Stage registers: ctrl word plus valid for EX, MEM, WB. Each advances one stage per cycle; no stage ever holds.
- Bubble: EX valid=0. Inserted when stall, ex_redirect or id_valid=0.
- Hazard with forwarding: stall=1 when EX is valid LWD, EX dst equals a used ID source, and id_valid=1. One bubble only.
- Hazard without forwarding: stall=1 while a valid writer in EX or MEM has dst equal to a used ID source. The regfile is write-before-read, so WB is excluded.
- ex_redirect: flush_id=1, ID instruction squashed into a bubble, stall forced 0. Redirect wins over hazard stall and over HLT entry.
- fwd_a/fwd_b: MEM match has priority over WB; matches only on valid writers; never forward from LWD in MEM.
- HLT FSM, RUN → DRAIN → HALTED:
  - RUN → DRAIN when an unsquashed HLT leaves ID.
  - In DRAIN and HALTED, stall=1 and id_valid is ignored (bubbles only).
  - DRAIN → HALTED when HLT is in WB.
  - HALTED is exited only by reset.
- num_inst: +1 per cycle WB is valid (HLT counts). Wraps at 2^CNT_W−1 → 0.
- Reset value of every output, state and counter is 0; FSM state is RUN. Reset mid-drain returns to RUN with pipe empty.

## Timing
- Instruction in ID at edge t appears on ex_* at t+1, MEM at t+2, wb_* at t+3.
- stall, flush_id, fwd_a, fwd_b: combinational, same cycle.
- halted rises one cycle after HLT is in WB.
- num_inst updates at the edge ending the WB cycle.
- wwd reaches WB 3 cycles after ID.

## Configuration
- PIPE_CTRL_UNIT_FWD_EN defined: forwarding selects active; stall on load-use only.
- Undefined: fwd_a=fwd_b=0; full EX/MEM interlock.

## Structure
- Package pipe_ctrl_pkg holds:
  - opcode and func localparams (ALU, LHI, LWD, SWD, JMP, JAL, JPR, JRL, WWD, HLT);
  - ctrl_t packed struct;
  - fwd_sel_e enum;
  - fsm state enum.
- Sub-module pipe_ctrl_decode: combinational opcode/func → ctrl_t plus use_rs/use_rt.

## Test plan
- LWD $1 then ADD $2,$1,$3 (fwd on) → stall=1 for exactly one cycle, ADD reaches EX with fwd_a=2 next cycle.
- ADD $1 then SUB $2,$1,$1 (fwd off) → stall for 2 cycles; fwd on → no stall, fwd_a=fwd_b=1.
- ex_redirect with a load-use stall pending → flush_id=1, stall=0, EX bubble next cycle.
- HLT after 3 ALU ops from reset → halted=1 at t+4, num_inst=4; later id_valid ignored.
- HLT in ID with ex_redirect=1 → HLT squashed, FSM stays RUN.
- CNT_W=4, 17 retirements → num_inst=1; reset asserted mid-DRAIN → all outputs 0 asynchronously.
